// File: rtl/init_dot_scanner.sv
// Raster timing generator and scan stage feeding the 48x16-dot INIT mask.
// Produces the mask lookup address and a two-stage registered, sync-aligned video stream.
module init_dot_scanner #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int DOT_SHIFT = 3,
    parameter int ORIGIN_X  = 128,
    parameter int ORIGIN_Y  = 176
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_en,
    input  logic       show,
    output logic [3:0] dot_x,
    output logic [3:0] dot_y,
    input  logic       pixell,
    input  logic       pixelc,
    input  logic       pixelr,
    output logic       video,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [VW-1:0] V_ONE  = VW'(1);
    localparam logic [HW-1:0] ORG_X  = HW'(ORIGIN_X);
    localparam logic [VW-1:0] ORG_Y  = VW'(ORIGIN_Y);

    // Range limits widened to 32 bits so the window edge may sit past the counter range.
    localparam logic [31:0] HS_LO = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_HI = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_LO = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_HI = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] X_LO  = 32'(ORIGIN_X);
    localparam logic [31:0] X_HI  = 32'(ORIGIN_X + (48 << DOT_SHIFT));
    localparam logic [31:0] Y_LO  = 32'(ORIGIN_Y);
    localparam logic [31:0] Y_HI  = 32'(ORIGIN_Y + (16 << DOT_SHIFT));
    localparam logic [31:0] H_ACT = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT = 32'(V_ACTIVE);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          show_latched;

    logic [31:0] h_wide;
    logic [31:0] v_wide;
    logic        hs_raw;
    logic        vs_raw;
    logic        at_origin;
    logic        in_window;
    logic [5:0]  col;
    logic [3:0]  row;

    logic [1:0]  seg_d;
    logic        in_window_d;
    logic        hs_d;
    logic        vs_d;
    logic        fs_d;
    logic        pix_sel;

    // Offsets are only formed inside the window, so the subtraction never underflows.
    always_comb begin
        h_wide    = 32'(h_cnt);
        v_wide    = 32'(v_cnt);
        hs_raw    = (h_wide >= HS_LO) && (h_wide < HS_HI);
        vs_raw    = (v_wide >= VS_LO) && (v_wide < VS_HI);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        in_window = (h_wide >= X_LO) && (h_wide < X_HI) &&
                    (v_wide >= Y_LO) && (v_wide < Y_HI) &&
                    (h_wide < H_ACT) && (v_wide < V_ACT) && show_latched;
        col = '0;
        row = '0;
        if (in_window) begin
            col = 6'((h_cnt - ORG_X) >> DOT_SHIFT);
            row = 4'((v_cnt - ORG_Y) >> DOT_SHIFT);
        end
    end

    always_comb begin
        pix_sel = pixelr;
        if (seg_d == 2'd0) begin
            pix_sel = pixell;
        end else if (seg_d == 2'd1) begin
            pix_sel = pixelc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            show_latched <= 1'b0;
            dot_x        <= '0;
            dot_y        <= '0;
            seg_d        <= '0;
            in_window_d  <= 1'b0;
            hs_d         <= 1'b0;
            vs_d         <= 1'b0;
            fs_d         <= 1'b0;
            video        <= 1'b0;
            hsync_n      <= 1'b1;
            vsync_n      <= 1'b1;
            frame_start  <= 1'b0;
        end else begin
            // frame_start is a single-clock pulse even when pix_en is sparse.
            frame_start <= 1'b0;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_ONE;
                end else begin
                    h_cnt <= h_cnt + H_ONE;
                end
                if (at_origin) begin
                    show_latched <= show;
                end

                dot_x       <= col[3:0];
                dot_y       <= row;
                seg_d       <= col[5:4];
                in_window_d <= in_window;
                hs_d        <= hs_raw;
                vs_d        <= vs_raw;
                fs_d        <= at_origin;

                video       <= in_window_d & pix_sel;
                hsync_n     <= ~hs_d;
                vsync_n     <= ~vs_d;
                frame_start <= fs_d;
            end
        end
    end

endmodule

// File: tb/tb_init_dot_scanner.sv
// Randomised bench for init_dot_scanner on a shrunken raster, checked against a
// position-from-tick-count model of the scan with its own dot mask.
module tb_init_dot_scanner;

    localparam int HA = 120, HFP = 4, HSW = 8, HBP = 8;
    localparam int VA = 40, VFP = 2, VSW = 2, VBP = 3;
    localparam int DS = 1, OX = 12, OY = 4;
    localparam int H_TOTAL = HA + HFP + HSW + HBP;
    localparam int V_TOTAL = VA + VFP + VSW + VBP;
    localparam int FRAME = H_TOTAL * V_TOTAL;

    logic clk = 1'b0;
    logic reset_n, pix_en, show;
    logic pixell, pixelc, pixelr;
    logic [3:0] dot_x, dot_y;
    logic video, hsync_n, vsync_n, frame_start;

    always #5 clk = ~clk;

    init_dot_scanner #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .DOT_SHIFT(DS), .ORIGIN_X(OX), .ORIGIN_Y(OY)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .show(show),
        .dot_x(dot_x), .dot_y(dot_y),
        .pixell(pixell), .pixelc(pixelc), .pixelr(pixelr),
        .video(video), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .frame_start(frame_start)
    );

    bit mask [16][48];
    bit force_ones;

    // Mask model: answers the DUT's lookup address, or all ones when forced.
    always_comb begin
        pixell = force_ones | mask[int'(dot_y)][int'(dot_x)];
        pixelc = force_ones | mask[int'(dot_y)][16 + int'(dot_x)];
        pixelr = force_ones | mask[int'(dot_y)][32 + int'(dot_x)];
    end

    logic [11:0] obs_vec;
    logic [11:0] exp_vec;
    assign obs_vec = {dot_x, dot_y, video, hsync_n, vsync_n, frame_start};
    localparam logic [11:0] RESET_VEC = 12'b0000_0000_0110;

    int  ticks;
    bit  last_en;
    bit  show_frame [int];
    int  n_cmp, n_fail;

    function automatic int hpos(int q);
        return q % H_TOTAL;
    endfunction

    function automatic int vpos(int q);
        return (q / H_TOTAL) % V_TOTAL;
    endfunction

    function automatic bit in_win(int q);
        int h = hpos(q);
        int v = vpos(q);
        return h >= OX && h < OX + (48 << DS) && v >= OY && v < OY + (16 << DS) &&
               h < HA && v < VA && show_frame[q / FRAME];
    endfunction

    function automatic bit pix_model(int q);
        int c = (hpos(q) - OX) >> DS;
        int r = (vpos(q) - OY) >> DS;
        return force_ones ? 1'b1 : mask[r][c];
    endfunction

    // After n enabled ticks, stage 1 reflects raster tick n-1 and stage 2 tick n-2.
    function automatic void compute_expected();
        int n = ticks;
        int dx = 0, dy = 0, h, v;
        bit vid = 1'b0, hs_n = 1'b1, vs_n = 1'b1, fs = 1'b0;
        if (n >= 1 && in_win(n - 1)) begin
            dx = ((hpos(n - 1) - OX) >> DS) % 16;
            dy = (vpos(n - 1) - OY) >> DS;
        end
        if (n >= 2) begin
            h = hpos(n - 2);
            v = vpos(n - 2);
            vid  = in_win(n - 2) ? pix_model(n - 2) : 1'b0;
            hs_n = !(h >= HA + HFP && h < HA + HFP + HSW);
            vs_n = !(v >= VA + VFP && v < VA + VFP + VSW);
            fs   = last_en && h == 0 && v == 0;
        end
        exp_vec = {4'(dx), 4'(dy), vid, hs_n, vs_n, fs};
    endfunction

    task automatic tick(input bit en);
        pix_en = en;
        @(posedge clk);
        if (en) begin
            if (ticks % FRAME == 0) show_frame[ticks / FRAME] = show;
            ticks++;
        end
        last_en = en;
        #1;
        compute_expected();
    endtask

    task automatic advance_to(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= FRAME; i++) begin
            tick(1'b1);
            if (hpos(ticks - 1) == h && vpos(ticks - 1) == v) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic model_reset();
        ticks   = 0;
        last_en = 1'b0;
        show_frame.delete();
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        pix_en     = 1'b0;
        show       = 1'b1;
        force_ones = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_vec !== RESET_VEC) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %b want %b", obs_vec, RESET_VEC);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_full_frame();
        int fs_cnt = 0, hs_low = 0, vs_low = 0;
        for (int i = 0; i < FRAME + 300; i++) begin
            tick(1'b1);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL full_frame tick=%0d: got %b want %b", ticks, obs_vec, exp_vec);
            end
            if (i >= 300) begin
                fs_cnt += int'(frame_start);
                hs_low += int'(!hsync_n);
                vs_low += int'(!vsync_n);
            end
        end
        n_cmp += 3;
        if (fs_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL frame_start_count: got %0d want 1", fs_cnt);
        end
        if (hs_low != V_TOTAL * HSW) begin
            n_fail++;
            $display("[TB] FAIL hsync_low_count: got %0d want %0d", hs_low, V_TOTAL * HSW);
        end
        if (vs_low != VSW * H_TOTAL) begin
            n_fail++;
            $display("[TB] FAIL vsync_low_count: got %0d want %0d", vs_low, VSW * H_TOTAL);
        end
    endtask

    task automatic test_dot_map();
        int ph   [7] = '{11, 12, 24, 44, 76, 106, 108};
        int pdx  [7] = '{0, 0, 6, 0, 0, 15, 0};
        int pcol [7] = '{-1, 0, 6, 16, 32, 47, -1};
        bit ok;
        bit exp_v;
        for (int k = 0; k < 7; k++) begin
            advance_to(ph[k], 6, ok);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL dot_map_timeout h=%0d: got none want position", ph[k]);
            end else if ({dot_x, dot_y} !== {4'(pdx[k]), (pcol[k] < 0) ? 4'd0 : 4'd1}) begin
                n_fail++;
                $display("[TB] FAIL dot_map h=%0d: got x=%0d y=%0d want x=%0d", ph[k], dot_x, dot_y, pdx[k]);
            end
            tick(1'b1);
            exp_v = (pcol[k] < 0) ? 1'b0 : mask[1][pcol[k]];
            n_cmp++;
            if (video !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL dot_video h=%0d: got %b want %b", ph[k], video, exp_v);
            end
        end
    endtask

    task automatic test_outside_ones();
        int lit = 0;
        force_ones = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b1);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL outside_ones tick=%0d: got %b want %b", ticks, obs_vec, exp_vec);
            end
            lit += int'(video);
        end
        n_cmp++;
        if (lit != (48 << DS) * (16 << DS)) begin
            n_fail++;
            $display("[TB] FAIL window_area: got %0d want %0d", lit, (48 << DS) * (16 << DS));
        end
        force_ones = 1'b0;
    endtask

    task automatic test_show_midframe();
        int lit = 0, ones = 0, guard = 0;
        show = 1'b0;
        while (ticks % FRAME != 1 && guard < 2 * FRAME) begin
            tick(1'b1);
            guard++;
        end
        while (ticks % FRAME != 0 && guard < 3 * FRAME) begin
            tick(1'b1);
            guard++;
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL show_off tick=%0d: got %b want %b", ticks, obs_vec, exp_vec);
            end
            if (vpos(ticks - 1) == 10) show = 1'b1;
            lit += int'(video);
        end
        n_cmp++;
        if (lit != 0 || guard >= 3 * FRAME) begin
            n_fail++;
            $display("[TB] FAIL show_midframe_lit: got %0d want 0", lit);
        end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 48; c++) ones += int'(mask[r][c]);
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b1);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL show_next tick=%0d: got %b want %b", ticks, obs_vec, exp_vec);
            end
            lit += int'(video);
        end
        n_cmp++;
        if (lit != ones * (1 << (2 * DS))) begin
            n_fail++;
            $display("[TB] FAIL show_next_lit: got %0d want %0d", lit, ones * (1 << (2 * DS)));
        end
    endtask

    task automatic test_sparse_reset();
        int guard = 0;
        while (!(ticks > 0 && vpos(ticks - 1) == 20 && hpos(ticks - 1) == 37) && guard < FRAME) begin
            for (int j = 0; j < 4; j++) begin
                tick(j == 3);
                n_cmp++;
                if (obs_vec !== exp_vec) begin
                    n_fail++;
                    $display("[TB] FAIL sparse tick=%0d: got %b want %b", ticks, obs_vec, exp_vec);
                end
            end
            guard++;
        end
        n_cmp++;
        if (guard >= FRAME) begin
            n_fail++;
            $display("[TB] FAIL sparse_timeout: got %0d ticks want line 20", guard);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec !== RESET_VEC) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %b want %b", obs_vec, RESET_VEC);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 4; j++) begin
                tick(j == 3);
                n_cmp++;
                if (obs_vec !== exp_vec) begin
                    n_fail++;
                    $display("[TB] FAIL restart tick=%0d: got %b want %b", ticks, obs_vec, exp_vec);
                end
            end
            if (k == 1) begin
                n_cmp++;
                if (frame_start !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL restart_frame_start: got %b want 1", frame_start);
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 48; c++)
                mask[r][c] = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        mask[1][0] = 1'b0;
        mask[1][6] = 1'b1;
        test_reset();
        test_full_frame();
        test_dot_map();
        test_outside_ones();
        test_show_midframe();
        test_sparse_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/init_dot_scanner.md
Name: init_dot_scanner

Overview:
- Display-timing and scan stage that sits directly upstream of the "INIT" dot bit mask.
- Generates raster timing and maps the raster position onto the 48x16-dot INIT window.
- Drives the mask's 4-bit x/y lookup, selects the left, centre or right pixel it returns, and emits registered, sync-aligned video.
- Each logical dot is scaled to a square of 2^DOT_SHIFT by 2^DOT_SHIFT screen pixels.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
DOT_SHIFT, 3, log2 of screen pixels per dot (window is 384x128 at default)
ORIGIN_X, 128, first active column of the window
ORIGIN_Y, 176, first active line of the window

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
pix_en  input  1  pixel-rate clock enable; all state advances only when high
show  input  1  window enable; sampled once per frame
dot_x  output  4  dot column within the current 16-dot segment, to mask x
dot_y  output  4  dot row, to mask y
pixell  input  1  mask left-segment pixel (dot columns 0-15)
pixelc  input  1  mask centre-segment pixel (dot columns 16-31)
pixelr  input  1  mask right-segment pixel (dot columns 32-47)
video  output  1  registered pixel output; 1 = lit
hsync_n  output  1  active-low horizontal sync, aligned with video
vsync_n  output  1  active-low vertical sync, aligned with video
frame_start  output  1  one-clock pulse at h=0, v=0, aligned with video

Behaviour:
- Reset is asynchronous and active-low. During reset: h_cnt=0, v_cnt=0, dot_x=0, dot_y=0, video=0, hsync_n=1, vsync_n=1, frame_start=0, show_latched=0. Every pipeline valid and segment register clears.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). It wraps to 0 on a pix_en tick.
  - v_cnt increments when h_cnt wraps. It runs 0..V_TOTAL-1 (525) and then wraps to 0.
- Sync:
  - Raw hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Raw vsync uses the same rule on v_cnt with the V_* parameters.
- show is latched into show_latched on the pix_en tick where h_cnt=0 and v_cnt=0. A change mid-frame has no effect until the next frame.
- Window test:
  - The window is active when ORIGIN_X <= h_cnt < ORIGIN_X+(48<<DOT_SHIFT).
  - It also requires ORIGIN_Y <= v_cnt < ORIGIN_Y+(16<<DOT_SHIFT).
  - It also requires h_cnt < H_ACTIVE, v_cnt < V_ACTIVE and show_latched=1.
- Dot mapping:
  - col = (h_cnt-ORIGIN_X)>>DOT_SHIFT, range 0..47.
  - seg = col/16, where 0=left, 1=centre, 2=right.
  - dot_x = col%16.
  - dot_y = (v_cnt-ORIGIN_Y)>>DOT_SHIFT.
  - Outside the window, dot_x=0 and dot_y=0. The mask returns 0 for row 0.
- Pipeline stage 1 (tick N): dot_x, dot_y, seg, in_window and the raw syncs are registered from the counters. The mask is combinational off dot_x/dot_y.
- Pipeline stage 2 (tick N+1):
  - video <= in_window_d ? (seg_d==0 ? pixell : seg_d==1 ? pixelc : pixelr) : 0.
  - hsync_n, vsync_n and frame_start are registered from their stage-1 copies.
- Latency: 2 pix_en ticks from the counter value to video, with the syncs identical.
- When pix_en=0, every register holds. frame_start must not stretch; it is cleared on any clk where pix_en=0.
- An outside-window pixel is 0 even if the mask inputs are 1.
- Wrap-around:
  - At h_cnt=H_TOTAL-1 with v_cnt=V_TOTAL-1, both counters go to 0 on the same tick.
  - frame_start asserts 2 ticks later.
- A reset asserted mid-frame clears all state immediately. Scanning restarts at h=0, v=0 after release, with the first frame_start 2 ticks after the first pix_en.
- All counter and offset arithmetic is unsigned, sized to clog2(H_TOTAL) and clog2(V_TOTAL). The subtraction is evaluated only when the window test is true, so no negative values occur.

Test Plan:
- Reset, then pix_en held at 1 for one full frame -> exactly one frame_start per 420000 ticks. hsync_n is low for 96 ticks per line, starting 2 ticks after h_cnt=656. vsync_n is low for 2 lines starting at v_cnt=490.
- show=1 with a mask model, at raster h=128, v=184 -> dot_x=0, dot_y=1, seg=0. video equals pixell (0) 2 ticks later. At h=176 (col 6), video=1.
- Raster h=256 and h=384 on line v=184 -> seg=1 with dot_x=0, and seg=2 with dot_x=0. video follows pixelc, then pixelr.
- Mask inputs forced to 1 at h=127, h=512, v=175 and v=304 -> video=0 (outside the window).
- show toggled to 1 mid-frame -> video stays 0 for the rest of that frame. The window appears in the next frame.
- pix_en=1 every 4th clk, and reset_n pulsed low at v=200 -> all outputs go to their reset values asynchronously. Timing restarts at h=0, v=0, with frame_start 2 enabled ticks after release.
